// File: rtl/out_port_arbiter_if.sv
// rtl/out_port_arbiter_if.sv - switch/inject/link/credit signal bundle for out_port_arbiter
interface out_port_arbiter_if #(
  parameter int FLIT_SIZE = 82,
  parameter int CREDIT_W  = 5
);
  logic [FLIT_SIZE-1:0] sw_flit;
  logic                 sw_valid;
  logic                 sw_ready;
  logic [FLIT_SIZE-1:0] inj_flit;
  logic                 inj_valid;
  logic                 inj_ready;
  logic [FLIT_SIZE-1:0] out_flit;
  logic                 out_valid;
  logic                 credit_in;
  logic [CREDIT_W-1:0]  credit_count;
  logic                 credit_err;

  modport master (
    output sw_flit, sw_valid, inj_flit, inj_valid, credit_in,
    input  sw_ready, inj_ready, out_flit, out_valid, credit_count, credit_err
  );

  modport slave (
    input  sw_flit, sw_valid, inj_flit, inj_valid, credit_in,
    output sw_ready, inj_ready, out_flit, out_valid, credit_count, credit_err
  );
endinterface

// File: rtl/out_port_arbiter.sv
// rtl/out_port_arbiter.sv - buffered, credit-gated switch/inject arbiter for one link output
// Define OUT_ARB_INJECT_PRIORITY_EN for strict inject priority; default is round-robin.
module out_port_arbiter_fifo #(
  parameter int W = 82
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         ready,
  output logic         nonempty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: head is only consumed while cnt is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign ready    = (cnt != 2'd2);
  assign nonempty = (cnt != 2'd0);
  assign head     = mem[rd_ptr];
endmodule

module out_port_arbiter #(
  parameter int FLIT_SIZE   = 82,
  parameter int CREDIT_INIT = 16,
  parameter int CREDIT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  out_port_arbiter_if.slave  bus
);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDIT_INIT);

  logic                 sw_push, sw_pop, sw_ne;
  logic                 inj_push, inj_pop, inj_ne;
  logic [FLIT_SIZE-1:0] sw_head, inj_head;
  logic                 grant, pick_sw;
  logic [CREDIT_W-1:0]  credit_q;
  logic                 credit_err_q;
  logic                 out_valid_q;
  logic [FLIT_SIZE-1:0] out_flit_q;

  assign sw_push  = bus.sw_valid  && bus.sw_ready;
  assign inj_push = bus.inj_valid && bus.inj_ready;

  out_port_arbiter_fifo #(.W(FLIT_SIZE)) u_sw_fifo (
    .clk(clk), .rst(rst), .push(sw_push), .din(bus.sw_flit), .pop(sw_pop),
    .ready(bus.sw_ready), .nonempty(sw_ne), .head(sw_head)
  );

  out_port_arbiter_fifo #(.W(FLIT_SIZE)) u_inj_fifo (
    .clk(clk), .rst(rst), .push(inj_push), .din(bus.inj_flit), .pop(inj_pop),
    .ready(bus.inj_ready), .nonempty(inj_ne), .head(inj_head)
  );

`ifdef OUT_ARB_INJECT_PRIORITY_EN
  always_comb begin
    grant   = (credit_q != '0) && (sw_ne || inj_ne);
    pick_sw = sw_ne && !inj_ne;
  end
`else
  logic last_inj;

  always_comb begin
    grant   = (credit_q != '0) && (sw_ne || inj_ne);
    pick_sw = sw_ne && (!inj_ne || last_inj);
  end

  // Reset to "inj granted last" so the switch wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_inj <= 1'b1;
    else if (grant) last_inj <= !pick_sw;
  end
`endif

  assign sw_pop  = grant && pick_sw;
  assign inj_pop = grant && !pick_sw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      out_valid_q <= grant;
      out_flit_q  <= grant ? (pick_sw ? sw_head : inj_head) : '0;
    end
  end

  // A grant and a returning credit in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q     <= CREDIT_MAX;
      credit_err_q <= 1'b0;
    end else if (grant && !bus.credit_in) begin
      credit_q <= credit_q - CREDIT_W'(1);
    end else if (!grant && bus.credit_in) begin
      if (credit_q == CREDIT_MAX) credit_err_q <= 1'b1;
      else                        credit_q     <= credit_q + CREDIT_W'(1);
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_flit     = out_flit_q;
  assign bus.credit_count = credit_q;
  assign bus.credit_err   = credit_err_q;
endmodule
